// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit oversampling,
// start-glitch rejection and stop-bit framing check.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] word,
  output logic       recieve_ready,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state, state_n;
  logic          sync1, rxd_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    word_n;
  logic          rdy_n, ferr_n;

  assign dbg_state = state;

  // rxd is asynchronous; only the second flop output is ever used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      word          <= '0;
      recieve_ready <= 1'b0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bit_idx       <= bit_idx_n;
      shift         <= shift_n;
      word          <= word_n;
      recieve_ready <= rdy_n;
      frame_err     <= ferr_n;
      busy          <= (state_n != IDLE);
    end
  end

  // recieve_ready is a one-cycle valid with no ready: the consumer cannot
  // stall the line, so word must be captured on the pulse or it may be lost.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    word_n    = word;
    rdy_n     = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == MID) begin
          cnt_n = '0;
          if (!rxd_s) begin
            state_n   = DATA;
            bit_idx_n = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n            = '0;
          shift_n[bit_idx] = rxd_s;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (rxd_s) begin
            word_n  = shift;
            rdy_n   = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      // A held-low break must return high before a new start is recognised.
      WAIT_HIGH: begin
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16 clocks/bit main instance plus an odd
// 5 clocks/bit instance for the integer mid-point.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int CPB5 = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       rxd5 = 1'b1;
  logic [7:0] word, word5;
  logic       rdy, rdy5, ferr, ferr5, busy, busy5;
  logic [2:0] st, st5;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .word(word), .recieve_ready(rdy),
    .frame_err(ferr), .busy(busy), .dbg_state(st)
  );

  uart_rx #(.CLKS_PER_BIT(CPB5)) dut5 (
    .clk(clk), .rst(rst), .rxd(rxd5), .word(word5), .recieve_ready(rdy5),
    .frame_err(ferr5), .busy(busy5), .dbg_state(st5)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: monitor pushes observed bytes, stimulus pushes expected ones
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int rdy_cnt = 0, ferr_cnt = 0, rdy5_cnt = 0, busy_cycles = 0, overlap_err = 0;
  int last_rdy_cyc = 0, prev_rdy_cyc = 0, last_rdy5_cyc = 0;
  logic prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (rdy) begin
      rdy_cnt++;
      prev_rdy_cyc = last_rdy_cyc;
      last_rdy_cyc = cyc;
      got_q.push_back(word);
    end
    if (ferr) ferr_cnt++;
    if (rdy && ferr) overlap_err++;
    if ((rdy || ferr) && prev_pulse) overlap_err++;
    prev_pulse = rdy || ferr;
    if (rdy5) begin
      rdy5_cnt++;
      last_rdy5_cyc = cyc;
    end
    if (busy) busy_cycles++;
  end

  task automatic drain_check(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  // driver tasks: called on a negedge, return on a negedge after the stop bit
  task automatic send16(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send5(input logic [7:0] b, output int start_cyc);
    rxd5 = 1'b0;
    start_cyc = cyc;
    repeat (CPB5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd5 = b[i];
      repeat (CPB5) @(negedge clk);
    end
    rxd5 = 1'b1;
    repeat (CPB5) @(negedge clk);
  endtask

  int s, s2, base, fbase, bbase, lat;
  logic [7:0] rb;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_word", word, 8'h00);
    check("reset_rdy", rdy, 1'b0);
    check("reset_ferr", ferr, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_state", st, 3'd0);
    check("reset_word5", word5, 8'h00);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // good frame 0xA5
    base = rdy_cnt; fbase = ferr_cnt;
    exp_q.push_back(8'hA5);
    send16(8'hA5, 1'b1, s);
    repeat (5) @(negedge clk);
    check("a5_word", word, 8'hA5);
    check("a5_pulses", rdy_cnt - base, 1);
    lat = last_rdy_cyc - s;
    check("a5_latency_155pm1", (lat >= 154 && lat <= 156), 1'b1);
    check("a5_no_ferr", ferr_cnt - fbase, 0);
    check("a5_busy_idle", busy, 1'b0);
    drain_check("a5");

    // 4-clock start glitch
    base = rdy_cnt; fbase = ferr_cnt; bbase = busy_cycles;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_rdy", rdy_cnt - base, 0);
    check("glitch_no_ferr", ferr_cnt - fbase, 0);
    check("glitch_busy_seen", (busy_cycles - bbase) > 0, 1'b1);
    check("glitch_busy_le10", (busy_cycles - bbase) <= 10, 1'b1);
    check("glitch_busy_idle", busy, 1'b0);
    check("glitch_word", word, 8'hA5);

    // 0x3C with low stop bit, line held low (break)
    base = rdy_cnt; fbase = ferr_cnt;
    send16(8'h3C, 1'b0, s);
    repeat (40) @(negedge clk);
    check("ferr_pulses", ferr_cnt - fbase, 1);
    check("ferr_no_rdy", rdy_cnt - base, 0);
    check("ferr_word_kept", word, 8'hA5);
    check("ferr_busy_held", busy, 1'b1);
    check("ferr_state_wait_high", st, 3'd4);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    check("ferr_busy_released", busy, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_no_spurious", rdy_cnt - base, 0);
    check("ferr_single_pulse", ferr_cnt - fbase, 1);

    // back-to-back 0x00 then 0xFF
    base = rdy_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send16(8'h00, 1'b1, s);
    send16(8'hFF, 1'b1, s2);
    repeat (5) @(negedge clk);
    check("b2b_pulses", rdy_cnt - base, 2);
    lat = last_rdy_cyc - prev_rdy_cyc;
    check("b2b_spacing_160pm1", (lat >= 159 && lat <= 161), 1'b1);
    check("b2b_word", word, 8'hFF);
    drain_check("b2b");

    // reset in the middle of bit 4 of 0x5A
    base = rdy_cnt;
    rb = 8'h5A;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = rb[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = rb[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_word", word, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rdy", rdy, 1'b0);
    check("midrst_state", st, 3'd0);
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h81);
    send16(8'h81, 1'b1, s);
    repeat (5) @(negedge clk);
    check("post_rst_pulses", rdy_cnt - base, 1);
    check("post_rst_word", word, 8'h81);
    drain_check("post_rst");

    // odd oversampling ratio
    base = rdy5_cnt;
    send5(8'h55, s);
    repeat (5) @(negedge clk);
    check("cpb5_word", word5, 8'h55);
    check("cpb5_pulses", rdy5_cnt - base, 1);
    lat = last_rdy5_cyc - s;
    check("cpb5_latency_50pm1", (lat >= 49 && lat <= 51), 1'b1);
    check("cpb5_busy_idle", busy5, 1'b0);

    check("pulse_overlap_or_repeat", overlap_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
